n1_ir_ctrl: RTL

//  Sequencer for the N1 instruction register. Owns the program-bus fetch handshake (wishbone pipelined: cyc/stb/ack/stall).

---
 rtl/n1_fc_pkg.sv | 26 ++
 rtl/n1_pbus_req.sv | 37 +++
 rtl/n1_ir_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/n1_fc_pkg.sv
// ---------------------------------------------------------------------------
// n1_fc_pkg : shared types for the N1 IR sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package n1_fc_pkg;

  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_EXEC = 3'd1,
    ST_MEM  = 3'd2
  } fc_state_e;

  typedef struct packed {
    logic eow;
    logic call0;
    logic drop;
    logic isr;
  } fc_force_t;

  localparam int unsigned RST_CALL_CYC_MAX = 7;

endpackage

`default_nettype wire

// File: rtl/n1_pbus_req.sv
// ---------------------------------------------------------------------------
// n1_pbus_req : single-outstanding pipelined-wishbone request tracker
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module n1_pbus_req (
  input  logic clk_i,
  input  logic async_rst_i,
  input  logic req_i,
  input  logic ack_i,
  input  logic stall_i,
  output logic cyc_o,
  output logic stb_o,
  output logic xfer_o
);

  logic pend_q;
  logic pend_d;

  // xfer_o is independent of req_i so the sequencer can qualify it without a loop
  assign xfer_o = ack_i & (pend_q | ~stall_i);
  assign cyc_o  = req_i;
  assign stb_o  = req_i & ~pend_q;
  assign pend_d = req_i & ~ack_i & (pend_q | ~stall_i);

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/n1_ir_ctrl.sv
// ---------------------------------------------------------------------------
// n1_ir_ctrl : N1 instruction-register sequencer and program-bus fetch control
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module n1_ir_ctrl
  import n1_fc_pkg::*;
#(
  parameter int unsigned RST_CALL_CYC = 1
) (
  input  logic       clk_i,
  input  logic       async_rst_i,
  output logic       pbus_cyc_o,
  output logic       pbus_stb_o,
  input  logic       pbus_ack_i,
  input  logic       pbus_stall_i,
  input  logic       ir2fc_eow_i,
  input  logic       ir2fc_eow_postpone_i,
  input  logic       ir2fc_jump_or_call_i,
  input  logic       ir2fc_bra_i,
  input  logic       ir2fc_scyc_i,
  input  logic       ir2fc_mem_i,
  input  logic       prs2fc_hold_i,
  input  logic       prs2fc_ps0_false_i,
  input  logic       irq_req_i,
  output logic       irq_ack_o,
  output logic       fc2ir_capture_o,
  output logic       fc2ir_stash_o,
  output logic       fc2ir_expend_o,
  output logic       fc2ir_force_eow_o,
  output logic       fc2ir_force_0call_o,
  output logic       fc2ir_force_drop_o,
  output logic       fc2ir_force_isr_o,
  output logic [2:0] prb_fc_state_o
);

  localparam logic [2:0] RST_CNT_END = 3'(RST_CALL_CYC);

  if (RST_CALL_CYC < 1 || RST_CALL_CYC > RST_CALL_CYC_MAX) begin : g_bad_rst_call_cyc
    $error("RST_CALL_CYC out of range 1..7");
  end

  fc_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       bus_req;
  logic       bus_xfer;
  logic       capture;
  logic       stash;
  logic       expend;
  fc_force_t  frc;

  n1_pbus_req u_pbus_req (
    .clk_i       (clk_i),
    .async_rst_i (async_rst_i),
    .req_i       (bus_req),
    .ack_i       (pbus_ack_i),
    .stall_i     (pbus_stall_i),
    .cyc_o       (pbus_cyc_o),
    .stb_o       (pbus_stb_o),
    .xfer_o      (bus_xfer)
  );

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      state_q <= ST_RST;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bus_req = 1'b0;
    capture = 1'b0;
    stash   = 1'b0;
    expend  = 1'b0;
    frc     = '0;
    case (state_q)
      ST_RST: begin
        if (cnt_q == RST_CNT_END) begin
          capture   = 1'b1;
          frc.call0 = 1'b1;
          cnt_d     = 3'd0;
          state_d   = ST_EXEC;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_EXEC: begin
        if (!prs2fc_hold_i) begin
          // A not-taken branch just drops the condition from the IR; no fetch needed
          if (ir2fc_bra_i && !prs2fc_ps0_false_i) begin
            capture  = 1'b1;
            frc.drop = 1'b1;
          end else if (ir2fc_mem_i && !ir2fc_bra_i) begin
            bus_req = 1'b1;
            if (bus_xfer) begin
              stash   = 1'b1;
              state_d = ST_MEM;
            end
          end else if (ir2fc_scyc_i || ir2fc_jump_or_call_i || ir2fc_bra_i) begin
            bus_req = 1'b1;
            if (bus_xfer) begin
              capture = 1'b1;
              frc.isr = irq_req_i && !ir2fc_eow_postpone_i && !ir2fc_bra_i && !ir2fc_mem_i;
            end
          end
        end
      end
      ST_MEM: begin
        bus_req = 1'b1;
        if (bus_xfer) begin
          expend  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      default: state_d = ST_RST;
    endcase
    frc.eow = capture & ir2fc_eow_postpone_i;
  end

  assign fc2ir_capture_o     = capture;
  assign fc2ir_stash_o       = stash;
  assign fc2ir_expend_o      = expend;
  assign fc2ir_force_eow_o   = frc.eow;
  assign fc2ir_force_0call_o = frc.call0;
  assign fc2ir_force_drop_o  = frc.drop;
  assign fc2ir_force_isr_o   = frc.isr;
  assign irq_ack_o           = frc.isr;
  assign prb_fc_state_o      = state_q;

  // EOW of the current word is consumed by the IR itself, not by the sequencer
  logic unused_ok;
  assign unused_ok = ir2fc_eow_i;

endmodule

`default_nettype wire
